// File: rtl/forth_fetch_unit.sv
// Fetch stage: owns the program counter, latches instructions into ir and
// resolves jump/call/ret against a small hardware return-address stack.
module forth_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          RS_DEPTH = 16,
    parameter int          RS_AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [15:0]      target,
    output logic [15:0]      pc,
    input  logic [15:0]      instr_in,
    output logic [15:0]      ir,
    output logic [15:0]      ir_pc,
    output logic             ir_valid,
    output logic [RS_AW:0]   rs_count,
    output logic             rs_overflow,
    output logic             rs_underflow
);

    localparam logic [15:0]    PC_INIT = RESET_PC & 16'hFFFE;
    localparam logic [RS_AW:0] RS_FULL = (RS_AW+1)'(RS_DEPTH);

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_RET,
        ACT_CALL,
        ACT_JUMP,
        ACT_SEQ
    } act_t;

    act_t act;

    logic [15:0]      stack [RS_DEPTH];
    logic [15:0]      tgt_even;
    logic [15:0]      push_val;
    logic [15:0]      pop_val;
    logic [RS_AW:0]   cnt_dec;
    logic [RS_AW-1:0] push_idx;
    logic [RS_AW-1:0] pop_idx;
    logic             rs_empty;
    logic             rs_full;
    logic             do_push;

    logic [15:0]      pc_nxt;
    logic [15:0]      ir_nxt;
    logic [15:0]      ir_pc_nxt;
    logic             ir_valid_nxt;
    logic [RS_AW:0]   rs_count_nxt;
    logic             rs_overflow_nxt;
    logic             rs_underflow_nxt;

    assign tgt_even = target & 16'hFFFE;
    assign push_val = ir_pc + 16'd2;
    assign cnt_dec  = rs_count - 1'b1;
    assign push_idx = rs_count[RS_AW-1:0];
    assign pop_idx  = cnt_dec[RS_AW-1:0];
    assign pop_val  = stack[pop_idx] & 16'hFFFE;
    assign rs_empty = (rs_count == '0);
    assign rs_full  = (rs_count == RS_FULL);

    // Control inputs are only meaningful while ir holds a real instruction.
    always_comb begin
        act = ACT_SEQ;
        if (stall)
            act = ACT_HOLD;
        else if (ir_valid && ret)
            act = ACT_RET;
        else if (ir_valid && call)
            act = ACT_CALL;
        else if (ir_valid && jump)
            act = ACT_JUMP;
    end

    always_comb begin
        pc_nxt           = pc;
        ir_nxt           = ir;
        ir_pc_nxt        = ir_pc;
        ir_valid_nxt     = ir_valid;
        rs_count_nxt     = rs_count;
        rs_overflow_nxt  = rs_overflow;
        rs_underflow_nxt = rs_underflow;
        do_push          = 1'b0;

        unique case (act)
            ACT_HOLD: ;
            ACT_RET: begin
                ir_valid_nxt = 1'b0;
                if (rs_empty) begin
                    pc_nxt           = PC_INIT;
                    rs_underflow_nxt = 1'b1;
                end else begin
                    pc_nxt       = pop_val;
                    rs_count_nxt = cnt_dec;
                end
            end
            ACT_CALL: begin
                pc_nxt       = tgt_even;
                ir_valid_nxt = 1'b0;
                if (rs_full) begin
                    rs_overflow_nxt = 1'b1;
                end else begin
                    do_push      = 1'b1;
                    rs_count_nxt = rs_count + 1'b1;
                end
            end
            ACT_JUMP: begin
                pc_nxt       = tgt_even;
                ir_valid_nxt = 1'b0;
            end
            ACT_SEQ: begin
                ir_nxt       = instr_in;
                ir_pc_nxt    = pc;
                ir_valid_nxt = 1'b1;
                pc_nxt       = pc + 16'd2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= PC_INIT;
            ir           <= 16'h0000;
            ir_pc        <= 16'h0000;
            ir_valid     <= 1'b0;
            rs_count     <= '0;
            rs_overflow  <= 1'b0;
            rs_underflow <= 1'b0;
        end else begin
            pc           <= pc_nxt;
            ir           <= ir_nxt;
            ir_pc        <= ir_pc_nxt;
            ir_valid     <= ir_valid_nxt;
            rs_count     <= rs_count_nxt;
            rs_overflow  <= rs_overflow_nxt;
            rs_underflow <= rs_underflow_nxt;
        end
    end

    // Stack storage is left uninitialised; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (!reset && do_push)
            stack[push_idx] <= push_val;
    end

endmodule

// File: tb/tb_forth_fetch_unit.sv
// Scoreboard bench for forth_fetch_unit: a reference model pushes expected
// state per driven cycle; the sampler pops and compares after each edge.
module tb_forth_fetch_unit;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [15:0] target = 16'h0000;
    logic [15:0] pc;
    logic [15:0] instr_in;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic [4:0]  rs_count;
    logic        rs_overflow;
    logic        rs_underflow;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] ir_pc;
        logic        v;
        logic [4:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];

    logic [15:0] m_pc, m_ir, m_irpc;
    logic        m_v, m_ovf, m_unf;
    int          m_cnt;
    logic [15:0] m_stk [DEPTH];

    forth_fetch_unit #(.RESET_PC(16'h0000), .RS_DEPTH(DEPTH), .RS_AW(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .call(call),
        .ret(ret), .target(target), .pc(pc), .instr_in(instr_in), .ir(ir),
        .ir_pc(ir_pc), .ir_valid(ir_valid), .rs_count(rs_count),
        .rs_overflow(rs_overflow), .rs_underflow(rs_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[13:1], 3'b101} ^ 16'h3C00;
    endfunction

    assign instr_in = mem_word(pc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic model(input logic r, s, j, c, rt, input logic [15:0] t);
        if (r) begin
            m_pc = 16'h0000; m_ir = 16'h0000; m_irpc = 16'h0000;
            m_v = 1'b0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (s) begin
        end else if (rt && m_v) begin
            m_v = 1'b0;
            if (m_cnt == 0) begin
                m_pc = 16'h0000;
                m_unf = 1'b1;
            end else begin
                m_cnt--;
                m_pc = m_stk[m_cnt];
            end
        end else if (c && m_v) begin
            if (m_cnt == DEPTH) m_ovf = 1'b1;
            else begin
                m_stk[m_cnt] = m_irpc + 16'd2;
                m_cnt++;
            end
            m_pc = {t[15:1], 1'b0};
            m_v = 1'b0;
        end else if (j && m_v) begin
            m_pc = {t[15:1], 1'b0};
            m_v = 1'b0;
        end else begin
            m_ir = mem_word(m_pc);
            m_irpc = m_pc;
            m_v = 1'b1;
            m_pc = m_pc + 16'd2;
        end
    endtask

    task automatic step(input logic r, s, j, c, rt, input logic [15:0] t);
        exp_t e;
        @(negedge clk);
        reset = r; stall = s; jump = j; call = c; ret = rt; target = t;
        model(r, s, j, c, rt, t);
        exp_q.push_back('{m_pc, m_ir, m_irpc, m_v, 5'(m_cnt), m_ovf, m_unf});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("sb_pc", pc, e.pc);
            chk("sb_ir", ir, e.ir);
            chk("sb_ir_pc", ir_pc, e.ir_pc);
            chk("sb_valid", ir_valid, e.v);
            chk("sb_cnt", rs_count, e.cnt);
            chk("sb_ovf", rs_overflow, e.ovf);
            chk("sb_unf", rs_underflow, e.unf);
        end
    endtask

    task automatic seq();
        step(0, 0, 0, 0, 0, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and free-running fetch
        step(1, 0, 0, 0, 0, 16'h0000);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_valid", ir_valid, 0);
        for (int i = 0; i < 4; i++) begin
            seq();
            chk("seq_pc", pc, 2 * (i + 1));
            chk("seq_ir", ir, mem_word(16'(2 * i)));
            chk("seq_ir_pc", ir_pc, 2 * i);
            chk("seq_valid", ir_valid, 1);
        end
        seq();
        chk("pre_jump_ir_pc", ir_pc, 16'h0008);

        // Jump with odd target
        step(0, 0, 1, 0, 0, 16'h1001);
        chk("jump_pc", pc, 16'h1000);
        chk("jump_bubble", ir_valid, 0);
        seq();
        chk("jump_ir", ir, mem_word(16'h1000));
        chk("jump_ir_pc", ir_pc, 16'h1000);

        // Call at 0x0010 then return
        step(0, 0, 1, 0, 0, 16'h0010);
        seq();
        chk("call_site", ir_pc, 16'h0010);
        step(0, 0, 0, 1, 0, 16'h1020);
        chk("call_cnt", rs_count, 1);
        chk("call_pc", pc, 16'h1020);
        seq();
        step(0, 0, 0, 0, 1, 16'h0000);
        chk("ret_pc", pc, 16'h0012);
        chk("ret_cnt", rs_count, 0);
        chk("ret_bubble", ir_valid, 0);

        // Stall with jump held
        seq();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 0, 16'h2000);
            chk("stall_pc", pc, 16'h0014);
        end
        step(0, 0, 1, 0, 0, 16'h2000);
        chk("unstall_jump", pc, 16'h2000);

        // Overflow then underflow
        seq();
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 0, 1, 0, 16'h0100);
            seq();
        end
        chk("ovf_cnt", rs_count, 16);
        chk("ovf_flag", rs_overflow, 1);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0, 1, 16'h0000);
            seq();
        end
        chk("empty_cnt", rs_count, 0);
        chk("no_unf_yet", rs_underflow, 0);
        step(0, 0, 0, 0, 1, 16'h0000);
        chk("unf_pc", pc, 16'h0000);
        chk("unf_flag", rs_underflow, 1);
        chk("ovf_sticky", rs_overflow, 1);

        // Wrap at top of address space
        seq();
        step(0, 0, 1, 0, 0, 16'hFFFE);
        chk("top_pc", pc, 16'hFFFE);
        seq();
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_ir_pc", ir_pc, 16'hFFFE);

        // Reset in the middle of a call sequence
        step(0, 0, 0, 1, 0, 16'h0300);
        seq();
        step(1, 0, 0, 1, 0, 16'h0400);
        chk("mid_rst_pc", pc, 16'h0000);
        chk("mid_rst_cnt", rs_count, 0);
        chk("mid_rst_flags", {rs_overflow, rs_underflow}, 0);
        chk("mid_rst_ir", ir, 16'h0000);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99) < 2, $urandom_range(99) < 20,
                 $urandom_range(99) < 15, $urandom_range(99) < 20,
                 $urandom_range(99) < 15, 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
